// File: rtl/iomem_gpio.sv
// GPIO peripheral for the PicoSoC iomem bus: OUT/OE registers, atomic
// set/clear/toggle, synchronised inputs and edge-capture interrupts.
// Ports: clk, resetn (async, active low); iomem_valid/ready/wstrb/addr/
// wdata/rdata bus; gpio_in pads; gpio_out, gpio_oe pad drives; irq.
module iomem_gpio #(
  parameter int         WIDTH       = 8,
  parameter logic [7:0] BASE        = 8'h03,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic             sel;
  logic             wr;
  logic [3:0]       off;
  logic [15:0]      hit;
  logic [31:0]      bmask;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] d;
  logic [31:0]      rval;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_s;
  logic [WIDTH-1:0] in_p;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] stat;
  logic [WIDTH-1:0] w1c;

  logic             unused;

  assign sel = iomem_valid && !iomem_ready
            && iomem_addr[31:24] == BASE;
  assign wr  = sel && (iomem_wstrb != 4'b0000);
  assign off = iomem_addr[5:2];
  assign hit = wr ? (16'd1 << off) : 16'd0;

  assign bmask = {{8{iomem_wstrb[3]}},
                  {8{iomem_wstrb[2]}},
                  {8{iomem_wstrb[1]}},
                  {8{iomem_wstrb[0]}}};
  assign m = bmask[WIDTH-1:0];
  assign d = iomem_wdata[WIDTH-1:0] & m;

  assign unused = ^{iomem_addr[23:6], iomem_addr[1:0],
                    iomem_wdata, bmask};

  assign in_s = sync_q[SYNC_STAGES-1];
  assign rise = in_s & ~in_p;
  assign fall = ~in_s & in_p;
  assign w1c  = hit[8] ? d : '0;
  assign irq  = |stat;

  always_comb begin
    rval = '0;
    unique case (off)
      4'd0:    rval[WIDTH-1:0] = gpio_out;
      4'd1:    rval[WIDTH-1:0] = gpio_oe;
      4'd2:    rval[WIDTH-1:0] = in_s;
      4'd6:    rval[WIDTH-1:0] = rise_en;
      4'd7:    rval[WIDTH-1:0] = fall_en;
      4'd8:    rval[WIDTH-1:0] = stat;
      default: rval = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      in_p <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      in_p <= in_s;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      gpio_out    <= '0;
      gpio_oe     <= '0;
      rise_en     <= '0;
      fall_en     <= '0;
      stat        <= '0;
    end else begin
      iomem_ready <= sel;
      iomem_rdata <= sel ? rval : '0;
      unique case (1'b1)
        hit[0]:  gpio_out <= (gpio_out & ~m) | d;
        hit[3]:  gpio_out <= gpio_out | d;
        hit[4]:  gpio_out <= gpio_out & ~d;
        hit[5]:  gpio_out <= gpio_out ^ d;
        default: gpio_out <= gpio_out;
      endcase
      if (hit[1]) gpio_oe <= (gpio_oe & ~m) | d;
      if (hit[6]) rise_en <= (rise_en & ~m) | d;
      if (hit[7]) fall_en <= (fall_en & ~m) | d;
      // new events OR in after the clear, so a same-cycle set wins
      stat <= (stat & ~w1c)
            | (rise & rise_en)
            | (fall & fall_en);
    end
  end

endmodule

// File: tb/tb_iomem_gpio.sv
// Scoreboard bench for iomem_gpio: random bus traffic and pad changes
// checked against a register-level reference model.
module tb_iomem_gpio;

  localparam int          W    = 8;
  localparam int          S    = 2;
  localparam logic [31:0] MASK = (32'd1 << W) - 32'd1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          iomem_valid = 1'b0;
  logic          iomem_ready;
  logic [3:0]    iomem_wstrb = 4'h0;
  logic [31:0]   iomem_addr = '0;
  logic [31:0]   iomem_wdata = '0;
  logic [31:0]   iomem_rdata;
  logic [W-1:0]  gpio_in = '0;
  logic [W-1:0]  gpio_out;
  logic [W-1:0]  gpio_oe;
  logic          irq;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q [$];

  logic [31:0] m_out, m_oe, m_pad;
  logic [31:0] m_rise, m_fall, m_stat, m_evt;

  iomem_gpio #(.WIDTH(W), .BASE(8'h03), .SYNC_STAGES(S)) dut (
    .clk(clk), .resetn(resetn),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_oe = 0; m_rise = 0;
    m_fall = 0; m_stat = 0; m_evt = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] off);
    case (off)
      4'd0:    return m_out;
      4'd1:    return m_oe;
      4'd2:    return m_pad;
      4'd6:    return m_rise;
      4'd7:    return m_fall;
      4'd8:    return m_stat;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_write(input logic [3:0] off,
                             input logic [3:0] strb,
                             input logic [31:0] wd);
    logic [31:0] bm, dd;
    bm = 0;
    for (int k = 0; k < 4; k++)
      if (strb[k]) bm = bm | (32'hFF << (8 * k));
    bm = bm & MASK;
    dd = wd & bm;
    case (off)
      4'd0: m_out = (m_out & ~bm) | dd;
      4'd1: m_oe = (m_oe & ~bm) | dd;
      4'd3: m_out = m_out | dd;
      4'd4: m_out = m_out & ~dd;
      4'd5: m_out = m_out ^ dd;
      4'd6: m_rise = (m_rise & ~bm) | dd;
      4'd7: m_fall = (m_fall & ~bm) | dd;
      4'd8: m_stat = (m_stat & ~dd) | m_evt;
      default: ;
    endcase
    m_evt = 0;
  endtask

  task automatic bus(input logic [3:0] strb,
                     input logic [3:0] off,
                     input logic [31:0] wd,
                     input logic [31:0] junk);
    int n;
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_wstrb = strb;
    iomem_addr = {8'h03, junk[23:6], off, junk[1:0]};
    iomem_wdata = wd;
    exp_q.push_back(model_read(off));
    if (strb != 0) model_write(off, strb, wd);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!iomem_ready && n < 8);
    check("ready_latency", n, 1);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    check("gpio_out", {24'd0, gpio_out}, m_out);
    check("gpio_oe", {24'd0, gpio_oe}, m_oe);
    check("irq", {31'd0, irq}, {31'd0, m_stat != 0});
    @(negedge clk);
    check("ready_pulse", {31'd0, iomem_ready}, 0);
  endtask

  task automatic set_pins(input logic [31:0] v);
    logic [31:0] nv;
    nv = v & MASK;
    @(negedge clk);
    m_stat = m_stat | (nv & ~m_pad & m_rise)
                    | (~nv & m_pad & m_fall);
    m_stat = m_stat & MASK;
    m_pad = nv;
    gpio_in = nv[W-1:0];
    repeat (S + 2) @(negedge clk);
    check("irq_pins", {31'd0, irq}, {31'd0, m_stat != 0});
  endtask

  always @(negedge clk) begin
    if (resetn && iomem_ready) begin
      if (exp_q.size() == 0)
        check("unexpected_ready", 1, 0);
      else
        check("rdata", iomem_rdata, exp_q.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    m_pad = 0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    check("rst_ready", {31'd0, iomem_ready}, 0);
    check("rst_rdata", iomem_rdata, 0);
    check("rst_out", {24'd0, gpio_out}, 0);
    check("rst_oe", {24'd0, gpio_oe}, 0);
    check("rst_irq", {31'd0, irq}, 0);

    for (int o = 0; o < 10; o++)
      bus(4'h0, o[3:0], 32'h0, 32'h0);

    bus(4'hF, 4'd0, 32'h0000_00F0, 0);
    check("out_f0", {24'd0, gpio_out}, 32'hF0);
    bus(4'hF, 4'd3, 32'h0000_0003, 0);
    check("set_03", {24'd0, gpio_out}, 32'hF3);
    bus(4'hF, 4'd4, 32'h0000_0010, 0);
    check("clr_10", {24'd0, gpio_out}, 32'hE3);
    bus(4'hF, 4'd5, 32'h0000_0081, 0);
    check("tgl_81", {24'd0, gpio_out}, 32'h62);
    bus(4'hF, 4'd0, 32'hFFFF_FFFF, 0);
    bus(4'h0, 4'd0, 0, 0);
    check("out_ff", {24'd0, gpio_out}, 32'hFF);

    bus(4'hF, 4'd0, 32'h0, 0);
    bus(4'b0001, 4'd0, 32'hAABB_CCDD, 0);
    check("strb_dd", {24'd0, gpio_out}, 32'hDD);

    bus(4'hF, 4'd6, 32'h1, 0);
    bus(4'hF, 4'd7, 32'h2, 0);
    @(negedge clk);
    gpio_in = 8'h03;
    m_pad = 3;
    m_stat = 1;
    for (int k = 0; k <= S; k++) begin
      @(negedge clk);
      check("irq_latency", {31'd0, irq}, {31'd0, k == S});
    end
    repeat (2) @(negedge clk);
    bus(4'h0, 4'd8, 0, 0);
    set_pins(32'h0);
    check("stat_both", m_stat, 3);
    bus(4'h0, 4'd8, 0, 0);
    bus(4'hF, 4'd8, 32'h1, 0);
    bus(4'h0, 4'd8, 0, 0);
    bus(4'hF, 4'd8, 32'h2, 0);
    bus(4'h0, 4'd8, 0, 0);
    check("irq_clear", {31'd0, irq}, 0);

    @(negedge clk);
    gpio_in = 8'h01;
    m_pad = 1;
    repeat (S - 1) @(negedge clk);
    m_evt = 1;
    bus(4'hF, 4'd8, 32'h1, 0);
    bus(4'h0, 4'd8, 0, 0);
    check("collide_irq", {31'd0, irq}, 1);

    bus(4'hF, 4'd0, 32'h3C, 0);
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_wstrb = 4'hF;
    iomem_addr = 32'h0300_0000;
    iomem_wdata = 32'h5A;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, iomem_ready}, 0);
    check("mid_rst_out", {24'd0, gpio_out}, 0);
    check("mid_rst_irq", {31'd0, irq}, 0);
    repeat (2) @(negedge clk);
    model_reset();
    resetn = 1'b1;
    exp_q.push_back(model_read(4'd0));
    model_write(4'd0, 4'hF, 32'h5A);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!iomem_ready && n < 8);
    check("post_rst_latency", n, 1);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    check("post_rst_out", {24'd0, gpio_out}, 32'h5A);
    repeat (4) @(negedge clk);

    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 4) == 0)
        set_pins($urandom);
      else if ($urandom_range(0, 2) == 0)
        bus(4'h0, 4'($urandom_range(0, 9)), $urandom, $urandom);
      else
        bus(4'($urandom_range(1, 15)),
            4'($urandom_range(0, 9)),
            $urandom, $urandom);
    end
    for (int o = 0; o < 9; o++)
      bus(4'h0, o[3:0], 32'h0, 32'h0);

    repeat (3) @(negedge clk);
    check("queue_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
